// File: rtl/module_gray_scan_display_if.sv
// Gray-scan display bus: Gray input and blanking control in, multiplexed
// 7-segment drive plus conversion result out.
interface module_gray_scan_display_if #(
  parameter int WIDTH  = 4,
  parameter int DIGITS = 2
);
  logic [WIDTH-1:0]  gray_code;
  logic              blank_zeros;
  logic [DIGITS-1:0] anode_sel;
  logic [6:0]        display_code;
  logic [WIDTH-1:0]  bin_value;
  logic              conv_done;

  modport master (
    output gray_code, blank_zeros,
    input  anode_sel, display_code, bin_value, conv_done
  );

  modport slave (
    input  gray_code, blank_zeros,
    output anode_sel, display_code, bin_value, conv_done
  );
endinterface

// File: rtl/module_gray_scan_display.sv
// Synchronizes a Gray input, converts it to binary and BCD (double dabble),
// and scans the BCD digits onto a multiplexed active-low 7-segment display.
module module_gray_scan_display #(
  parameter int WIDTH          = 4,
  parameter int DIGITS         = 2,
  parameter int REFRESH_CYCLES = 27000
) (
  input logic clk,
  input logic rst,
  module_gray_scan_display_if.slave bus
);
  localparam int BW = 4 * DIGITS;
  localparam int SW = BW + WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int RW = $clog2(REFRESH_CYCLES);
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e                   state_q, state_d;
  logic [1:0][WIDTH-1:0]    sync_q;
  logic [SW-1:0]            shift_q, shift_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [WIDTH-1:0]         hold_q, hold_d;
  logic [WIDTH-1:0]         bin_q, bin_d;
  logic [DIGITS-1:0][3:0]   bcd_q, bcd_d;
  logic                     done_q, done_d;
  logic [RW-1:0]            ref_q, ref_d;
  logic [DW-1:0]            digit_q, digit_d;

  logic [WIDTH-1:0]         bin_dec;
  logic [SW-1:0]            dabble;
  logic [DIGITS-1:0]        zero_above;
  logic                     blank;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  // b[i] is the XOR of all Gray bits at or above i
  always_comb begin
    bin_dec = '0;
    for (int i = 0; i < WIDTH; i++) bin_dec[i] = ^(sync_q[1] >> i);
  end

  always_comb begin
    dabble = shift_q;
    for (int d = 0; d < DIGITS; d++)
      if (dabble[WIDTH+4*d +: 4] >= 4'd5)
        dabble[WIDTH+4*d +: 4] = dabble[WIDTH+4*d +: 4] + 4'd3;
    dabble = {dabble[SW-2:0], 1'b0};
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (bin_dec != bin_q) begin
        shift_d = {{BW{1'b0}}, bin_dec};
        hold_d  = bin_dec;
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        shift_d = dabble;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = DONE;
      end
      DONE: begin
        bin_d   = hold_q;
        bcd_d   = shift_q[SW-1 -: BW];
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ref_d   = ref_q + 1'b1;
    digit_d = digit_q;
    if (ref_q == RW'(REFRESH_CYCLES - 1)) begin
      ref_d   = '0;
      digit_d = (digit_q == DW'(DIGITS - 1)) ? '0 : digit_q + 1'b1;
    end
  end

  // zero_above[i]: digit i and every higher digit are zero
  always_comb begin
    logic hz;
    hz = 1'b1;
    zero_above = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      hz = hz & (bcd_q[i] == 4'd0);
      zero_above[i] = hz;
    end
  end

  assign blank            = bus.blank_zeros && (digit_q != '0) && zero_above[digit_q];
  assign bus.display_code = blank ? 7'h7F : seg7(bcd_q[digit_q]);
  assign bus.anode_sel    = ~(DIGITS'(1) << digit_q);
  assign bus.bin_value    = bin_q;
  assign bus.conv_done    = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sync_q  <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      done_q  <= 1'b0;
      ref_q   <= '0;
      digit_q <= '0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[0], bus.gray_code};
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      done_q  <= done_d;
      ref_q   <= ref_d;
      digit_q <= digit_d;
    end
  end
endmodule

// File: tb/tb_module_gray_scan_display.sv
// Scoreboard bench: stimulus pushes expected conversions, a negedge monitor
// pops and checks them whenever conv_done pulses.
module tb_module_gray_scan_display;
  localparam int W = 4, D = 2, R = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  module_gray_scan_display_if #(.WIDTH(W), .DIGITS(D)) bus ();
  module_gray_scan_display #(.WIDTH(W), .DIGITS(D), .REFRESH_CYCLES(R)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct { int bin; int cyc; } exp_t;
  exp_t q[$];
  int n_tests = 0, n_fail = 0;
  int cyc = 0;

  // hand-decoded Gray -> binary for codes 0..15
  int gray2bin [16] = '{0, 1, 3, 2, 7, 6, 4, 5, 15, 14, 12, 13, 8, 9, 11, 10};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int seg(input int n);
    case (n)
      0: seg = 'h40; 1: seg = 'h79; 2: seg = 'h24; 3: seg = 'h30; 4: seg = 'h19;
      5: seg = 'h12; 6: seg = 'h02; 7: seg = 'h78; 8: seg = 'h00; 9: seg = 'h10;
      default: seg = 'h7F;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.conv_done) begin
      if (q.size() == 0) begin
        chk("unexpected_conv_done", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("bin_value", int'(bus.bin_value), e.bin);
        if (e.cyc != 0) chk("done_latency", cyc, e.cyc);
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      chk("done_timeout", q.size(), 0);
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_digit(input int d, input int exp, input string name);
    logic [D-1:0] want;
    bit hit;
    want = ~(D'(1) << d);
    hit = 0;
    for (int i = 0; i < 4 * R * D && !hit; i++) begin
      @(negedge clk);
      if (bus.anode_sel == want) hit = 1;
    end
    if (!hit) chk({name, "_anode_timeout"}, 0, 1);
    else      chk(name, int'(bus.display_code), exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_anode", int'(bus.anode_sel), 2);
    chk("rst_display", int'(bus.display_code), 'h40);
    chk("rst_bin", int'(bus.bin_value), 0);
    chk("rst_done", int'(bus.conv_done), 0);
    rst = 1'b0;
  endtask

  initial begin
    int c, last;
    bus.gray_code   = '0;
    bus.blank_zeros = 1'b0;
    @(negedge clk);

    // reset with zero input: no conversion must follow
    do_reset();
    repeat (12) @(negedge clk);
    chk("idle_bin", int'(bus.bin_value), 0);

    // 1000 -> 15 with exact latency
    c = cyc;
    bus.gray_code = 4'b1000;
    q.push_back('{15, c + 8});
    drain();
    check_digit(0, 'h12, "g1000_d0");
    check_digit(1, 'h79, "g1000_d1");

    // full sweep from a clean reset
    do_reset();
    last = 0;
    for (int g = 0; g < 16; g++) begin
      bus.gray_code = W'(g);
      if (gray2bin[g] != last) q.push_back('{gray2bin[g], 0});
      last = gray2bin[g];
      drain();
      check_digit(0, seg(gray2bin[g] % 10), "sweep_d0");
      check_digit(1, seg(gray2bin[g] / 10), "sweep_d1");
    end

    // leading-zero blanking on 5
    bus.gray_code   = 4'b0111;
    bus.blank_zeros = 1'b1;
    q.push_back('{5, 0});
    drain();
    check_digit(1, 'h7F, "blank_d1");
    check_digit(0, 'h12, "blank_d0");
    bus.blank_zeros = 1'b0;
    check_digit(1, 'h40, "noblank_d1");

    // input change two cycles into SHIFT completes old value first
    c = cyc;
    bus.gray_code = 4'b0001;
    q.push_back('{1, c + 8});
    q.push_back('{10, 0});
    repeat (5) @(negedge clk);
    bus.gray_code = 4'b1111;
    drain();
    chk("restart_bin", int'(bus.bin_value), 10);

    // reset during SHIFT discards the partial result
    bus.gray_code = 4'b0001;
    repeat (5) @(negedge clk);
    bus.gray_code = 4'b0011;
    do_reset();
    q.push_back('{2, 0});
    drain();
    chk("post_rst_bin", int'(bus.bin_value), 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1);
  end
endmodule

// File: doc/module_gray_scan_display.md
MODULE_GRAY_SCAN_DISPLAY -- requirements
Module: module_gray_scan_display

Interface
REQ-001 SHALL have parameter WIDTH, default 4: Gray input width, legal range 2..10.
REQ-002 SHALL have parameter DIGITS, default 2: number of displayed decimal digits, at least ceil(WIDTH*log10(2)).
REQ-003 SHALL have parameter REFRESH_CYCLES, default 27000: clock cycles each digit stays lit, at least 2.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port gray_code, input, WIDTH bits: asynchronous Gray-coded value.
REQ-007 SHALL have port blank_zeros, input, 1 bit: 1 enables leading-zero blanking.
REQ-008 SHALL have port anode_sel, output, DIGITS bits: active-low one-hot digit enable; bit 0 is the units digit.
REQ-009 SHALL have port display_code, output, 7 bits: active-low segments, bit order {g,f,e,d,c,b,a}.
REQ-010 SHALL have port bin_value, output, WIDTH bits: last completed binary conversion.
REQ-011 SHALL have port conv_done, output, 1 bit: one-cycle pulse when a new conversion is committed.

Function
REQ-012 SHALL pass gray_code through a 2-flop synchronizer; all downstream logic uses only the second stage.
REQ-013 SHALL decode Gray to binary as b[WIDTH-1]=g[WIDTH-1], b[i]=b[i+1]^g[i].
REQ-014 SHALL implement a conversion FSM with states IDLE, SHIFT and DONE.
REQ-015 IDLE: when the decoded binary differs from bin_value, SHALL load the shift register and move to SHIFT; otherwise stay in IDLE.
REQ-016 SHIFT: SHALL do one double-dabble step per cycle (add 3 to every BCD nibble >=5, then shift left by 1) for exactly WIDTH cycles, then move to DONE.
REQ-017 DONE: for one cycle, SHALL copy the BCD result to the display register, copy the binary value to bin_value, drive conv_done=1, and return to IDLE.
REQ-018 Latency: conv_done SHALL be high in the cycle after edge E0+WIDTH+3, where E0 is the edge that first samples a new gray_code into the synchronizer.
REQ-019 A gray_code change during SHIFT SHALL NOT abort the conversion; the old value completes, then IDLE detects the mismatch and starts a new conversion.
REQ-020 bin_value and the displayed digits SHALL hold their previous values until DONE; no partial result is ever visible.
REQ-021 The refresh counter SHALL count 0..REFRESH_CYCLES-1; on wrap, the digit index SHALL advance, and after DIGITS-1 it SHALL return to 0.
REQ-022 anode_sel SHALL be low only on the bit of the current digit index.
REQ-023 display_code SHALL encode the selected BCD nibble: 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10; any other value=0x7F.
REQ-024 With blank_zeros=1, digit i>0 SHALL show 0x7F when it and every higher digit are zero; digit 0 SHALL never be blanked.
REQ-025 blank_zeros SHALL take effect combinationally on the digit currently displayed.

Reset
REQ-026 With rst=1 at a rising edge, the synchronizer, bin_value, BCD register, refresh counter and digit index SHALL clear to 0, the FSM SHALL go to IDLE, and conv_done SHALL be 0.
REQ-027 After reset, outputs SHALL be anode_sel with only bit 0 low, display_code=0x40 (or 0x40 on digit 0 with blanking on), bin_value=0, conv_done=0.
REQ-028 Reset mid-conversion SHALL discard the partial result with no conv_done; a nonzero synchronized input SHALL then start a fresh conversion.

Verification (WIDTH=4, DIGITS=2, REFRESH_CYCLES=4)
REQ-029 Reset with gray_code=0 -> anode_sel=2'b10, display_code=0x40, bin_value=0, conv_done never pulses.
REQ-030 gray_code=4'b1000 -> conv_done pulses 7 edges after sampling; bin_value=15; digit 0 shows 0x12 and digit 1 shows 0x79 while their anodes are low.
REQ-031 Sweep all 16 Gray codes, waiting for conv_done each time -> bin_value matches the reference decode; both digits show correct BCD segments.
REQ-032 gray_code=4'b0111, blank_zeros=1 -> bin_value=5; digit 1 shows 0x7F and digit 0 shows 0x12; with blank_zeros=0, digit 1 shows 0x40.
REQ-033 Change gray_code from 4'b0001 to 4'b1111 two cycles into SHIFT -> first conv_done gives bin_value=1, a second conv_done follows with bin_value=10.
REQ-034 Assert rst during SHIFT -> no conv_done, outputs at reset values; after release with gray_code=4'b0011, conv_done pulses and bin_value=2.
